// File: rtl/AHP_SLAVE_PKG.sv
// Shared bus types for the AHP slave and its initiators.
package AHP_SLAVE_PKG;
   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      BUSY    = 2'b01,
      NON_SEQ = 2'b10,
      SEQ     = 2'b11
   } HTRANS_ENUM;
endpackage

// File: rtl/ahp_master.sv
// Single-initiator AHB-style master: one client command becomes one SINGLE or
// INCRx burst with pipelined address/data phases and HREADY wait-state support.
module ahp_master
   import AHP_SLAVE_PKG::*;
(
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [31:0] cmd_addr,
   input  logic [1:0]  cmd_size,
   input  logic [2:0]  cmd_burst,
   input  logic [31:0] wdata,
   output logic        wdata_pop,
   output logic [31:0] rdata,
   output logic        rdata_valid,
   output logic        done,
   output logic        HSEL,
   output HTRANS_ENUM  HTRANS,
   output logic [31:0] HADDR,
   output logic        HWRITE,
   output logic [1:0]  HSIZE,
   output logic [2:0]  HBURST,
   output logic [31:0] HWDATA,
   input  logic        HREADY,
   input  logic [31:0] HRDATA
);
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_XFER  = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;

   logic [1:0]  state_q, state_d;
   logic [4:0]  beats_q, beats_d;
   logic        dvalid_q, dvalid_d;
   logic        dwrite_q, dwrite_d;
   logic        cmd_ready_q, cmd_ready_d;
   logic [31:0] rdata_q, rdata_d;
   logic        rvalid_q, rvalid_d;
   logic        done_q, done_d;
   logic        hsel_q, hsel_d;
   HTRANS_ENUM  htrans_q, htrans_d;
   logic [31:0] haddr_q, haddr_d;
   logic        hwrite_q, hwrite_d;
   logic [1:0]  hsize_q, hsize_d;
   logic [2:0]  hburst_q, hburst_d;
   logic [31:0] hwdata_q, hwdata_d;

   logic [2:0]  burst_norm;
   logic [4:0]  burst_beats;
   logic [1:0]  size_norm;

   // Unsupported burst codes collapse to SINGLE, both on the bus and in the beat count.
   always_comb begin
      burst_norm  = 3'b000;
      burst_beats = 5'd1;
      case (cmd_burst)
         3'b011:  begin burst_norm = 3'b011; burst_beats = 5'd4;  end
         3'b101:  begin burst_norm = 3'b101; burst_beats = 5'd8;  end
         3'b111:  begin burst_norm = 3'b111; burst_beats = 5'd16; end
         default: ;
      endcase
      size_norm = (cmd_size == 2'd3) ? 2'd2 : cmd_size;
   end

   always_comb begin
      state_d     = state_q;
      beats_d     = beats_q;
      dvalid_d    = dvalid_q;
      dwrite_d    = dwrite_q;
      cmd_ready_d = cmd_ready_q;
      rdata_d     = rdata_q;
      rvalid_d    = 1'b0;
      done_d      = 1'b0;
      hsel_d      = hsel_q;
      htrans_d    = htrans_q;
      haddr_d     = haddr_q;
      hwrite_d    = hwrite_q;
      hsize_d     = hsize_q;
      hburst_d    = hburst_q;
      hwdata_d    = hwdata_q;

      if (HREADY && dvalid_q && !dwrite_q) begin
         rdata_d  = HRDATA;
         rvalid_d = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            cmd_ready_d = 1'b1;
            if (cmd_valid && cmd_ready_q) begin
               cmd_ready_d = 1'b0;
               beats_d     = burst_beats;
               htrans_d    = NON_SEQ;
               haddr_d     = cmd_addr;
               hsel_d      = 1'b1;
               hwrite_d    = cmd_write;
               hsize_d     = size_norm;
               hburst_d    = burst_norm;
               state_d     = S_XFER;
            end
         end
         S_XFER: begin
            if (HREADY) begin
               dvalid_d = 1'b1;
               dwrite_d = hwrite_q;
               if (hwrite_q) hwdata_d = wdata;
               beats_d = beats_q - 5'd1;
               if (beats_q != 5'd1) begin
                  haddr_d  = haddr_q + (32'd1 << hsize_q);
                  htrans_d = SEQ;
               end else begin
                  htrans_d = IDLE;
                  hsel_d   = 1'b0;
                  state_d  = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            if (HREADY) begin
               dvalid_d    = 1'b0;
               done_d      = 1'b1;
               cmd_ready_d = 1'b1;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q     <= S_IDLE;
         beats_q     <= 5'd0;
         dvalid_q    <= 1'b0;
         dwrite_q    <= 1'b0;
         cmd_ready_q <= 1'b0;
         rdata_q     <= 32'd0;
         rvalid_q    <= 1'b0;
         done_q      <= 1'b0;
         hsel_q      <= 1'b0;
         htrans_q    <= IDLE;
         haddr_q     <= 32'd0;
         hwrite_q    <= 1'b0;
         hsize_q     <= 2'd0;
         hburst_q    <= 3'd0;
         hwdata_q    <= 32'd0;
      end else begin
         state_q     <= state_d;
         beats_q     <= beats_d;
         dvalid_q    <= dvalid_d;
         dwrite_q    <= dwrite_d;
         cmd_ready_q <= cmd_ready_d;
         rdata_q     <= rdata_d;
         rvalid_q    <= rvalid_d;
         done_q      <= done_d;
         hsel_q      <= hsel_d;
         htrans_q    <= htrans_d;
         haddr_q     <= haddr_d;
         hwrite_q    <= hwrite_d;
         hsize_q     <= hsize_d;
         hburst_q    <= hburst_d;
         hwdata_q    <= hwdata_d;
      end
   end

   // The client's FIFO head is consumed on the same edge that accepts the write address.
   assign wdata_pop   = (state_q == S_XFER) && HREADY && hwrite_q;
   assign cmd_ready   = cmd_ready_q;
   assign rdata       = rdata_q;
   assign rdata_valid = rvalid_q;
   assign done        = done_q;
   assign HSEL        = hsel_q;
   assign HTRANS      = htrans_q;
   assign HADDR       = haddr_q;
   assign HWRITE      = hwrite_q;
   assign HSIZE       = hsize_q;
   assign HBURST      = hburst_q;
   assign HWDATA      = hwdata_q;
endmodule

// File: tb/tb_ahp_master.sv
// Directed bench for ahp_master: hand-computed bus sequences checked cycle by cycle.
module tb_ahp_master;
   import AHP_SLAVE_PKG::*;

   logic        HCLK, HRESETn;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr;
   logic [1:0]  cmd_size;
   logic [2:0]  cmd_burst;
   logic [31:0] wdata, rdata, HADDR, HWDATA, HRDATA;
   logic        wdata_pop, rdata_valid, done, HSEL, HWRITE, HREADY;
   HTRANS_ENUM  HTRANS;
   logic [1:0]  HSIZE;
   logic [2:0]  HBURST;

   int vecs = 0;
   int errs = 0;
   int pops = 0, rvs = 0, dones = 0;
   int pops0, rvs0, dones0;

   logic [31:0] exp_addr [1:9];
   logic        exp_rv   [1:11];
   logic [31:0] exp_rd   [1:11];
   logic [31:0] drv_hrd  [1:11];

   ahp_master dut (
      .HCLK(HCLK), .HRESETn(HRESETn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_burst(cmd_burst),
      .wdata(wdata), .wdata_pop(wdata_pop), .rdata(rdata), .rdata_valid(rdata_valid),
      .done(done), .HSEL(HSEL), .HTRANS(HTRANS), .HADDR(HADDR), .HWRITE(HWRITE),
      .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA), .HREADY(HREADY), .HRDATA(HRDATA)
   );

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   always @(negedge HCLK) begin
      if (wdata_pop)   pops  <= pops + 1;
      if (rdata_valid) rvs   <= rvs + 1;
      if (done)        dones <= dones + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic nxt();
      @(posedge HCLK);
      #1;
   endtask

   task automatic issue(input logic w, input logic [31:0] a, input logic [1:0] s, input logic [2:0] b);
      cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_size = s; cmd_burst = b;
      nxt();
      cmd_valid = 1'b0;
   endtask

   initial begin
      exp_addr = '{32'hFFFF_FFF0, 32'hFFFF_FFF4, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'hFFFF_FFFC,
                   32'h0000_0000, 32'h0000_0004, 32'h0000_0008, 32'h0000_000C};
      exp_rv   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      exp_rd   = '{32'h0, 32'h0, 32'hB000_0001, 32'hB000_0002, 32'h0, 32'hB000_0003,
                   32'hB000_0004, 32'hB000_0005, 32'hB000_0006, 32'hB000_0007, 32'hB000_0008};
      drv_hrd  = '{32'h0, 32'hB000_0001, 32'hB000_0002, 32'h0BAD_0BAD, 32'hB000_0003,
                   32'hB000_0004, 32'hB000_0005, 32'hB000_0006, 32'hB000_0007, 32'hB000_0008, 32'h0};

      HRESETn = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_size = '0;
      cmd_burst = '0; wdata = '0; HREADY = 1'b1; HRDATA = '0;
      #2 HRESETn = 1'b0;

      // reset values
      @(negedge HCLK);
      chk("rst_cmd_ready", cmd_ready, 0);
      chk("rst_htrans", HTRANS, IDLE);
      chk("rst_haddr", HADDR, 0);
      chk("rst_hsel", HSEL, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_done", done, 0);
      nxt(); HRESETn = 1'b1;
      @(negedge HCLK); chk("rel_cmd_ready_low", cmd_ready, 0);
      nxt();           chk("rel_cmd_ready_high", cmd_ready, 1);

      // SINGLE word write
      pops0 = pops; dones0 = dones; wdata = 32'hDEAD_BEEF;
      issue(1'b1, 32'h10, 2'd2, 3'b000);
      @(negedge HCLK);
      chk("t1_htrans_c1", HTRANS, NON_SEQ);
      chk("t1_haddr_c1", HADDR, 32'h10);
      chk("t1_pop_c1", wdata_pop, 1);
      chk("t1_cmd_ready_c1", cmd_ready, 0);
      nxt(); @(negedge HCLK);
      chk("t1_htrans_c2", HTRANS, IDLE);
      chk("t1_hwdata_c2", HWDATA, 32'hDEAD_BEEF);
      chk("t1_done_c2", done, 0);
      nxt(); @(negedge HCLK);
      chk("t1_done_c3", done, 1);
      chk("t1_cmd_ready_c3", cmd_ready, 1);
      nxt();
      chk("t1_pops", pops - pops0, 1);
      chk("t1_dones", dones - dones0, 1);

      // SINGLE byte read with two address-phase wait states
      rvs0 = rvs; HRDATA = 32'h1111_1111;
      issue(1'b0, 32'h05, 2'd0, 3'b000);
      HREADY = 1'b0; @(negedge HCLK);
      chk("t2_htrans_c1", HTRANS, NON_SEQ);
      chk("t2_haddr_c1", HADDR, 32'h05);
      chk("t2_hsize_c1", HSIZE, 0);
      nxt(); @(negedge HCLK);
      chk("t2_haddr_c2", HADDR, 32'h05);
      chk("t2_htrans_c2", HTRANS, NON_SEQ);
      nxt(); HREADY = 1'b1; @(negedge HCLK);
      chk("t2_haddr_c3", HADDR, 32'h05);
      nxt(); HRDATA = 32'h0000_00A5; @(negedge HCLK);
      chk("t2_htrans_c4", HTRANS, IDLE);
      chk("t2_rvalid_c4", rdata_valid, 0);
      nxt(); HRDATA = 32'h2222_2222; @(negedge HCLK);
      chk("t2_rvalid_c5", rdata_valid, 1);
      chk("t2_rdata_c5", rdata, 32'h0000_00A5);
      chk("t2_done_c5", done, 1);
      nxt(); @(negedge HCLK);
      chk("t2_rvalid_c6", rdata_valid, 0);
      nxt();
      chk("t2_rvs", rvs - rvs0, 1);

      // INCR4 half-word write
      pops0 = pops; wdata = 32'h1001;
      issue(1'b1, 32'h20, 2'd1, 3'b011);
      for (int k = 1; k <= 4; k++) begin
         wdata = 32'h1000 + k;
         @(negedge HCLK);
         chk("t3_haddr", HADDR, 32'h20 + 2 * (k - 1));
         chk("t3_htrans", HTRANS, (k == 1) ? NON_SEQ : SEQ);
         chk("t3_hburst", HBURST, 3'b011);
         chk("t3_pop", wdata_pop, 1);
         if (k > 1) chk("t3_hwdata", HWDATA, 32'h1000 + k - 1);
         nxt();
      end
      @(negedge HCLK);
      chk("t3_htrans_end", HTRANS, IDLE);
      chk("t3_hwdata_end", HWDATA, 32'h1004);
      chk("t3_pop_end", wdata_pop, 0);
      nxt(); @(negedge HCLK);
      chk("t3_done", done, 1);
      nxt();
      chk("t3_pops", pops - pops0, 4);

      // INCR8 word read across the 4 GB wrap, wait state on beat 3's data phase
      rvs0 = rvs;
      issue(1'b0, 32'hFFFF_FFF0, 2'd2, 3'b101);
      for (int c = 1; c <= 11; c++) begin
         HREADY = (c != 4);
         HRDATA = drv_hrd[c];
         @(negedge HCLK);
         if (c <= 9) chk("t4_haddr", HADDR, exp_addr[c]);
         chk("t4_rvalid", rdata_valid, exp_rv[c]);
         if (exp_rv[c]) chk("t4_rdata", rdata, exp_rd[c]);
         if (c == 10) chk("t4_hsel_end", HSEL, 0);
         if (c == 11) chk("t4_done", done, 1);
         nxt();
      end
      chk("t4_rvs", rvs - rvs0, 8);
      HREADY = 1'b1;

      // unsupported burst and size codes
      issue(1'b0, 32'h40, 2'd3, 3'b010);
      @(negedge HCLK);
      chk("t5_hburst", HBURST, 3'b000);
      chk("t5_hsize", HSIZE, 2'b10);
      chk("t5_htrans_c1", HTRANS, NON_SEQ);
      nxt(); @(negedge HCLK);
      chk("t5_htrans_c2", HTRANS, IDLE);
      nxt(); @(negedge HCLK);
      chk("t5_done", done, 1);
      nxt();

      // reset in the middle of an INCR16 write
      dones0 = dones; wdata = 32'hCAFE_0000;
      issue(1'b1, 32'h100, 2'd2, 3'b111);
      nxt();
      chk("t6_haddr_b2", HADDR, 32'h104);
      chk("t6_htrans_b2", HTRANS, SEQ);
      #2 HRESETn = 1'b0;
      #1;
      chk("t6_htrans_rst", HTRANS, IDLE);
      chk("t6_hsel_rst", HSEL, 0);
      chk("t6_haddr_rst", HADDR, 0);
      chk("t6_hwdata_rst", HWDATA, 0);
      chk("t6_hburst_rst", HBURST, 0);
      chk("t6_hwrite_rst", HWRITE, 0);
      chk("t6_cmd_ready_rst", cmd_ready, 0);
      chk("t6_pop_rst", wdata_pop, 0);
      nxt(); nxt();
      HRESETn = 1'b1;
      @(negedge HCLK); chk("t6_cmd_ready_rel", cmd_ready, 0);
      nxt(); @(negedge HCLK);
      chk("t6_cmd_ready_up", cmd_ready, 1);
      nxt(); nxt();
      chk("t6_no_done", dones - dones0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule

// File: doc/ahp_master.md
# ahp_master

Single-initiator AHB-style master that turns one-shot commands from a local client into address/data-pipelined bus transfers toward the existing AHP slave. Supports SINGLE, INCR4, INCR8 and INCR16 bursts of byte, half-word and word transfers, and honours slave wait states via HREADY. It sits between the client logic (command, write-data and read-data ports) and the slave's bus ports. It also drives HSEL, since the system has no separate decoder.

## Interface
- No parameters. Bus width is fixed at 32 bits. HTRANS is typed HTRANS_ENUM from AHP_SLAVE_PKG: IDLE=00, BUSY=01, NON_SEQ=10, SEQ=11.
- HCLK  in  1  sole clock; all logic on rising edge
- HRESETn  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  master idle and able to accept a command
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  32  start address; caller guarantees alignment to cmd_size
- cmd_size  in  2  0 = byte, 1 = half-word, 2 = word; 3 is clamped to 2
- cmd_burst  in  3  000 SINGLE, 011 INCR4, 101 INCR8, 111 INCR16; any other code is treated as SINGLE
- wdata  in  32  write beat, presented first-word-fall-through
- wdata_pop  out  1  consume current wdata this cycle
- rdata  out  32  captured read beat
- rdata_valid  out  1  one-cycle strobe: rdata holds a new beat
- done  out  1  one-cycle strobe: last data phase of the command completed
- HSEL  out  1  slave select
- HTRANS  out  2  transfer type (HTRANS_ENUM)
- HADDR  out  32  address
- HWRITE  out  1  direction
- HSIZE  out  2  size
- HBURST  out  3  burst type as driven on the bus (unsupported codes are driven as 000)
- HWDATA  out  32  write data
- HREADY  in  1  slave ready; a low value extends the current data phase
- HRDATA  in  32  read data

## Operation
- States: S_IDLE, S_XFER (address phases in flight), S_DRAIN (final data phase outstanding).
- Reset values: cmd_ready=0, wdata_pop=0, rdata=0, rdata_valid=0, done=0, HSEL=0, HTRANS=IDLE, HADDR=0, HWRITE=0, HSIZE=0, HBURST=0, HWDATA=0. State resets to S_IDLE.
- S_IDLE:
  - cmd_ready=1 from the first edge after reset release.
  - On an edge with cmd_valid && cmd_ready: latch the command and load beats_left = 1/4/8/16.
  - Drive HTRANS=NON_SEQ, HADDR=cmd_addr, HSEL=1, HWRITE, HSIZE and HBURST. Clear cmd_ready. Go to S_XFER.
- S_XFER, on each edge with HREADY=1 (current address phase accepted):
  - Record the data-phase flags dphase_valid=1 and dphase_write=HWRITE.
  - For a write, HWDATA <= wdata. wdata_pop is high combinationally in this cycle (S_XFER && HREADY && HWRITE).
  - Decrement beats_left.
  - If beats remain: HADDR += (1 << HSIZE) mod 2^32 and HTRANS=SEQ.
  - Otherwise: HTRANS=IDLE, HSEL=0, and go to S_DRAIN.
- HREADY=0 in any state: HADDR, HTRANS, HWRITE, HSIZE, HBURST and HWDATA are all held unchanged.
- Read capture: on an edge with HREADY=1 and dphase_valid && !dphase_write, rdata <= HRDATA and rdata_valid <= 1. rdata_valid is 0 on all other edges.
- S_DRAIN: on the edge where HREADY=1, complete the final data phase (read capture as above), pulse done, set cmd_ready=1, and return to S_IDLE.
- BUSY is never issued. The master does not check 1 KB boundary crossing; the caller must avoid it.
- A reset assertion at any point, including mid-burst, immediately forces all reset values. The command is abandoned and no done is produced.

## Timing
- A command accepted at edge E0 drives NON_SEQ during E0..E1.
- Zero wait states:
  - A burst of N beats issues its address phases in cycles 1..N.
  - The final data phase occurs in cycle N+1.
  - done is high in cycle N+2, and cmd_ready returns the same cycle.
  - Minimum spacing between command acceptances is N+2 cycles.
- Each cycle with HREADY=0 adds exactly one cycle to the current phase pair.
- A write beat's HWDATA appears in the cycle after its address phase and stays stable until HREADY=1.
- A read beat's rdata_valid is asserted in the cycle after the HREADY=1 edge that ends its data phase.

## Test plan
- SINGLE word write, addr 0x10, wdata 0xDEADBEEF, HREADY tied 1:
  - NON_SEQ with HADDR=0x10 for 1 cycle, then HWDATA=0xDEADBEEF.
  - One wdata_pop; done 3 cycles after acceptance.
- SINGLE byte read, addr 0x05, slave holds HREADY=0 for 2 cycles:
  - Address/control held for those 2 cycles.
  - rdata equals HRDATA at the HREADY=1 edge; one rdata_valid pulse.
- INCR4 half-word write from 0x20:
  - HADDR sequence 0x20, 0x22, 0x24, 0x26 with HTRANS NON_SEQ, SEQ, SEQ, SEQ, then IDLE.
  - 4 wdata_pop pulses; HBURST=011 throughout.
- INCR8 word read from 0xFFFFFFF0 with HREADY low on beat 3:
  - Addresses wrap to 0x00000000 after 0xFFFFFFFC.
  - 8 rdata_valid pulses in order; beat 3 delayed by 1 cycle.
- cmd_burst=010 and cmd_size=3:
  - Issued as a single word transfer with HBURST=000 and HSIZE=10.
- HRESETn asserted during beat 2 of an INCR16:
  - All outputs are at reset values in the same cycle; no done.
  - cmd_ready=1 one edge after reset release.
